vme_local_bus_slave: RTL and testbench
======================================

// Module: vme_local_bus_slave
// PURPOSE
// FPGA-side VME slave stage, directly downstream of the CPLD VME decoder.
// Takes the CPLD's asynchronous FWS/FRS strobes and FA[4:0] word address.
// Synchronises them, runs one local-bus register transaction, and returns an active-low FDTACK.
// Gives user logic a single-clock, pulse-based register bus of 32 x 32-bit words.
// PARAMETERS
// TIMEOUT    64            max cycles in WAIT_ACK before forced completion (>=2)
// TO_DATA    32'hFFFF_FFFF read data returned on timeout
// PORTS
// SYSCLK        in   1   system clock (FSYSCLK from CPLD, 32 MHz)
// RSTN          in   1   asynchronous active-low reset
// FWS           in   1   write strobe from CPLD, async, active-high
// FRS           in   1   read strobe from CPLD, async, active-high
// FA            in   5   word address from CPLD, stable while strobe high
// D_IN          in   32  VME data bus, inbound
// D_OUT         out  32  VME data bus, outbound (read data)
// D_OE          out  1   drive enable for D_OUT, active-high
// FDTACK        out  1   DTACK to CPLD, active-low
// LOCAL_ADDR    out  5   register word address
// LOCAL_WDATA   out  32  write data
// LOCAL_WE      out  1   write pulse, 1 cycle
// LOCAL_RE      out  1   read pulse, 1 cycle
// LOCAL_RDATA   in   32  read data, valid with LOCAL_ACK
// LOCAL_ACK     in   1   completion from user logic, 1-cycle pulse
// TIMEOUT_FLAG  out  1   1-cycle pulse on forced completion
// BEHAVIOUR
// Reset (async, RSTN=0): state IDLE.
//   FDTACK=1, D_OE=0, D_OUT=0, LOCAL_WE=LOCAL_RE=0.
//   LOCAL_ADDR=0, LOCAL_WDATA=0, TIMEOUT_FLAG=0, sync flops=0, timeout counter=0.
// Sync: FWS and FRS each pass through a 2-FF synchroniser to give ws_s/rs_s.
//   FA and D_IN are not synchronised; they are sampled only on the edge-detect cycle.
// States: IDLE, ACCESS, WAIT_ACK, SETUP, DTACK, DRAIN.
// IDLE: on a rising edge of exactly one of ws_s/rs_s, latch the following:
//   LOCAL_ADDR<=FA; LOCAL_WDATA<=D_IN (write only); direction -> ACCESS.
//   If ws_s and rs_s are both high, or a strobe is already high when reset releases, there is no edge and nothing is done.
// ACCESS (1 cycle): LOCAL_WE (write) or LOCAL_RE (read) =1; counter cleared -> WAIT_ACK.
//   LOCAL_ACK is also sampled in this cycle, so a zero-wait slave is allowed.
// WAIT_ACK: counter increments each cycle.
//   On LOCAL_ACK with strobe still high: latch D_OUT<=LOCAL_RDATA (read) -> SETUP.
//   When counter reaches TIMEOUT-1 with no ack: D_OUT<=TO_DATA (read), TIMEOUT_FLAG pulse -> SETUP.
//   Ack and timeout in the same cycle: the ack wins and there is no flag.
//   If the strobe drops before ack/timeout (master abort): the remaining ack/timeout is still consumed.
//     -> DRAIN. FDTACK is never asserted in this case.
// SETUP (1 cycle): D_OE=1 for reads (data setup before DTACK) -> DTACK.
// DTACK: FDTACK=0, D_OE held for reads; wait for the synced strobe to go low.
//   Then FDTACK=1, D_OE=0 in the same registered update -> IDLE.
// DRAIN: FDTACK=1, D_OE=0; wait until ws_s=rs_s=0 -> IDLE.
// LOCAL_ACK outside ACCESS/WAIT_ACK is ignored.
// D_OE is never 1 during a write transaction.
// Latency, read with zero-wait ack: strobe edge at pin -> ws/rs_s edge 2 cycles.
//   Then +1 LOCAL_RE, +1 SETUP, +1 FDTACK low, for 5 cycles total.
// Release: strobe low at pin -> FDTACK high after 3 cycles.
// All outputs are registered; no combinational path from inputs to outputs.
// The counter is log2(TIMEOUT)+1 bits wide, saturates, and clears on ACCESS.
// TESTING
// Write: FA=5'h03, D_IN=32'hA5A5_0001, FWS=1, ack 2 cycles after WE.
//   -> one LOCAL_WE with ADDR=3 and WDATA=A5A50001; FDTACK low; D_OE stays 0.
//   -> FDTACK high within 3 cycles of FWS=0.
// Read: FA=5'h1F, FRS=1, LOCAL_RDATA=32'h1234_5678 with zero-wait ack.
//   -> D_OUT=12345678; D_OE=1 one cycle before FDTACK=0; both released after FRS=0.
// Timeout: FRS=1, no LOCAL_ACK.
//   -> TIMEOUT_FLAG pulse after TIMEOUT cycles in WAIT_ACK; D_OUT=FFFFFFFF; FDTACK=0.
// Abort: FWS=1, then FWS=0 before ack, then ack.
//   -> single LOCAL_WE; FDTACK stays 1; FSM back to IDLE.
// Illegal and ignored cases:
//   -> FWS and FRS high together: no LOCAL_WE/RE, FDTACK stays 1.
//   -> Stray LOCAL_ACK in IDLE: no effect.
// Reset mid-DTACK: assert RSTN=0 while FDTACK=0.
//   -> FDTACK=1 and D_OE=0 immediately (async).
//   -> With FRS still high after release: no new transaction until FRS toggles.

Source files
------------

// File: rtl/vme_local_bus_slave.sv
// VME slave stage sitting behind the CPLD decoder. Synchronises the CPLD
// read/write strobes, runs one pulse-based local-bus register access per
// strobe and answers with an active-low FDTACK. All outputs are registered.
module vme_local_bus_slave #(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] TO_DATA = 32'hFFFF_FFFF
) (
  input  logic        SYSCLK,
  input  logic        RSTN,
  input  logic        FWS,
  input  logic        FRS,
  input  logic [4:0]  FA,
  input  logic [31:0] D_IN,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  output logic        FDTACK,
  output logic [4:0]  LOCAL_ADDR,
  output logic [31:0] LOCAL_WDATA,
  output logic        LOCAL_WE,
  output logic        LOCAL_RE,
  input  logic [31:0] LOCAL_RDATA,
  input  logic        LOCAL_ACK,
  output logic        TIMEOUT_FLAG
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT_ACK,
    S_SETUP,
    S_DTACK,
    S_DRAIN
  } state_t;

  // bit 0 carries the write strobe, bit 1 the read strobe
  logic [1:0] strobe_pin;
  logic [1:0] strobe_s;
  logic [1:0] strobe_rise;

  assign strobe_pin = {FRS, FWS};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;

      // two-flop synchroniser plus a delayed copy for rising-edge detection
      always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          meta_reg <= strobe_pin[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign strobe_s[gi]    = sync_reg;
      assign strobe_rise[gi] = sync_reg & ~prev_reg;
    end
  endgenerate

  logic ws_s;
  logic rs_s;
  logic ws_rise;
  logic rs_rise;

  assign ws_s    = strobe_s[0];
  assign rs_s    = strobe_s[1];
  assign ws_rise = strobe_rise[0];
  assign rs_rise = strobe_rise[1];

  // A strobe already high at reset release would look like a rising edge
  // once the synchroniser fills; edges are ignored until the chain has
  // settled so such a strobe must toggle before it is served.
  logic [2:0] arm_reg;

  // arm shift register fills with ones after reset release
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      arm_reg <= '0;
    end else begin
      arm_reg <= {arm_reg[1:0], 1'b1};
    end
  end

  state_t        state_reg,  state_next;
  logic          dir_wr_reg, dir_wr_next;
  logic [CW-1:0] cnt_reg,    cnt_next;
  logic [4:0]    addr_reg,   addr_next;
  logic [31:0]   wdata_reg,  wdata_next;
  logic [31:0]   dout_reg,   dout_next;
  logic          oe_reg,     oe_next;
  logic          dtack_n_reg, dtack_n_next;
  logic          we_reg,     we_next;
  logic          re_reg,     re_next;
  logic          flag_reg,   flag_next;
  logic          cur_strobe;
  logic          timed_out;

  // strobe belonging to the transaction in flight
  assign cur_strobe = dir_wr_reg ? ws_s : rs_s;

  // next-state and next-output logic; outputs derive from the next state so
  // they land in the same registered update as the state change
  always_comb begin
    state_next  = state_reg;
    dir_wr_next = dir_wr_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    dout_next   = dout_reg;
    flag_next   = 1'b0;
    timed_out   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (arm_reg[2]) begin
          if (ws_rise && !rs_s) begin
            dir_wr_next = 1'b1;
            addr_next   = FA;
            wdata_next  = D_IN;
            state_next  = S_ACCESS;
          end else if (rs_rise && !ws_s) begin
            dir_wr_next = 1'b0;
            addr_next   = FA;
            state_next  = S_ACCESS;
          end
        end
      end

      S_ACCESS, S_WAIT_ACK: begin
        if (state_reg == S_ACCESS) begin
          cnt_next = '0;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
        // ack has priority over a timeout landing in the same cycle
        timed_out = (state_reg == S_WAIT_ACK) && !LOCAL_ACK && (cnt_reg == CNT_LAST);
        if (LOCAL_ACK || timed_out) begin
          flag_next = timed_out;
          if (cur_strobe) begin
            if (!dir_wr_reg) begin
              dout_next = LOCAL_ACK ? LOCAL_RDATA : TO_DATA;
            end
            state_next = S_SETUP;
          end else begin
            // master gave up: finish quietly without DTACK
            state_next = S_DRAIN;
          end
        end else if (state_reg == S_ACCESS) begin
          state_next = S_WAIT_ACK;
        end
      end

      S_SETUP: begin
        state_next = S_DTACK;
      end

      S_DTACK: begin
        if (!cur_strobe) begin
          state_next = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (!ws_s && !rs_s) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    we_next      = (state_next == S_ACCESS) && dir_wr_next;
    re_next      = (state_next == S_ACCESS) && !dir_wr_next;
    oe_next      = ((state_next == S_SETUP) || (state_next == S_DTACK)) && !dir_wr_next;
    dtack_n_next = (state_next != S_DTACK);
  end

  // state and registered outputs
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg   <= S_IDLE;
      dir_wr_reg  <= 1'b0;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      dout_reg    <= '0;
      oe_reg      <= 1'b0;
      dtack_n_reg <= 1'b1;
      we_reg      <= 1'b0;
      re_reg      <= 1'b0;
      flag_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dir_wr_reg  <= dir_wr_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      dout_reg    <= dout_next;
      oe_reg      <= oe_next;
      dtack_n_reg <= dtack_n_next;
      we_reg      <= we_next;
      re_reg      <= re_next;
      flag_reg    <= flag_next;
    end
  end

  assign D_OUT        = dout_reg;
  assign D_OE         = oe_reg;
  assign FDTACK       = dtack_n_reg;
  assign LOCAL_ADDR   = addr_reg;
  assign LOCAL_WDATA  = wdata_reg;
  assign LOCAL_WE     = we_reg;
  assign LOCAL_RE     = re_reg;
  assign TIMEOUT_FLAG = flag_reg;

endmodule

// File: tb/tb_vme_local_bus_slave.sv
// Bench for vme_local_bus_slave: a user-logic responder with a programmable
// ack delay, directed scenarios and a randomized transaction run checked
// against a register-file model and the expected cycle latencies.
module tb_vme_local_bus_slave;

  localparam int TIMEOUT = 64;

  logic        SYSCLK = 1'b0;
  logic        RSTN   = 1'b0;
  logic        FWS    = 1'b0;
  logic        FRS    = 1'b0;
  logic [4:0]  FA     = '0;
  logic [31:0] D_IN   = '0;
  logic [31:0] D_OUT;
  logic        D_OE;
  logic        FDTACK;
  logic [4:0]  LOCAL_ADDR;
  logic [31:0] LOCAL_WDATA;
  logic        LOCAL_WE;
  logic        LOCAL_RE;
  logic [31:0] LOCAL_RDATA;
  logic        LOCAL_ACK;
  logic        TIMEOUT_FLAG;

  vme_local_bus_slave #(.TIMEOUT(TIMEOUT), .TO_DATA(32'hFFFF_FFFF)) dut (
    .SYSCLK      (SYSCLK),
    .RSTN        (RSTN),
    .FWS         (FWS),
    .FRS         (FRS),
    .FA          (FA),
    .D_IN        (D_IN),
    .D_OUT       (D_OUT),
    .D_OE        (D_OE),
    .FDTACK      (FDTACK),
    .LOCAL_ADDR  (LOCAL_ADDR),
    .LOCAL_WDATA (LOCAL_WDATA),
    .LOCAL_WE    (LOCAL_WE),
    .LOCAL_RE    (LOCAL_RE),
    .LOCAL_RDATA (LOCAL_RDATA),
    .LOCAL_ACK   (LOCAL_ACK),
    .TIMEOUT_FLAG(TIMEOUT_FLAG)
  );

  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input logic [4:0] a);
    return {16'hC0DE, 11'h000, a};
  endfunction

  // responder state (user logic stand-in)
  logic [31:0] resp_mem [32];
  bit          resp_written [32];
  bit          ack_enable = 1'b1;
  int          ack_delay  = 0;
  int          pend       = 0;
  bit          dly_ack    = 1'b0;
  bit          stray_ack  = 1'b0;
  bit          ovr_en     = 1'b0;
  logic [31:0] ovr_val    = '0;

  int          we_cnt = 0;
  int          re_cnt = 0;
  int          to_cnt = 0;
  logic [4:0]  last_we_addr = '0;
  logic [31:0] last_we_data = '0;

  // bench-side reference register file and expected D_OUT
  logic [31:0] model_mem [32];
  logic [31:0] exp_dout = '0;

  assign LOCAL_ACK   = dly_ack | stray_ack |
                       (ack_enable && (ack_delay == 0) && (LOCAL_WE || LOCAL_RE));
  assign LOCAL_RDATA = ovr_en ? ovr_val :
                       (resp_written[LOCAL_ADDR] ? resp_mem[LOCAL_ADDR] : init_word(LOCAL_ADDR));

  // responder and pulse monitor, sampled away from the active edge
  always @(negedge SYSCLK) begin
    if (pend > 0) begin
      pend    <= pend - 1;
      dly_ack <= (pend == 1);
    end else begin
      dly_ack <= 1'b0;
    end
    if ((LOCAL_WE || LOCAL_RE) && ack_enable && (ack_delay > 0)) pend <= ack_delay;
    if (LOCAL_WE) begin
      we_cnt                   <= we_cnt + 1;
      last_we_addr             <= LOCAL_ADDR;
      last_we_data             <= LOCAL_WDATA;
      resp_mem[LOCAL_ADDR]     <= LOCAL_WDATA;
      resp_written[LOCAL_ADDR] <= 1'b1;
    end
    if (LOCAL_RE) re_cnt <= re_cnt + 1;
    if (TIMEOUT_FLAG) to_cnt <= to_cnt + 1;
  end

  // drives one strobe cycle and measures the handshake (no checking here)
  task automatic run_txn(input bit wr, input logic [4:0] a, input logic [31:0] d,
                         output int lat, output int rel, output logic [31:0] dout,
                         output bit oe_pre, output bit oe_any, output bit oe_after);
    bit prev_oe;
    prev_oe = 1'b0; lat = -1; rel = -1; oe_pre = 1'b0; oe_any = 1'b0; oe_after = 1'b1;
    FA = a; D_IN = d;
    if (wr) FWS = 1'b1; else FRS = 1'b1;
    for (int k = 1; k <= TIMEOUT + 40; k++) begin
      @(negedge SYSCLK);
      if (D_OE) oe_any = 1'b1;
      if (FDTACK === 1'b0) begin
        lat = k; oe_pre = prev_oe;
        break;
      end
      prev_oe = D_OE;
    end
    dout = D_OUT;
    FWS = 1'b0; FRS = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge SYSCLK);
      if (FDTACK === 1'b1) begin
        rel = k; oe_after = D_OE;
        break;
      end
      if (D_OE) oe_any = 1'b1;
    end
    repeat (2) @(negedge SYSCLK);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge SYSCLK);
    checks++;
    if ({FDTACK, D_OE, LOCAL_WE, LOCAL_RE, TIMEOUT_FLAG} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 10000", {FDTACK, D_OE, LOCAL_WE, LOCAL_RE, TIMEOUT_FLAG});
    end
    checks++;
    if ({D_OUT, LOCAL_WDATA, LOCAL_ADDR} !== 69'd0) begin
      errors++;
      $display("FAIL reset_data: dout %h wdata %h addr %h expected all zero", D_OUT, LOCAL_WDATA, LOCAL_ADDR);
    end
    RSTN = 1'b1;
    repeat (5) @(negedge SYSCLK);
  endtask

  task automatic test_write();
    int lat, rel, w0;
    logic [31:0] dout;
    bit oe_pre, oe_any, oe_after;
    ack_delay = 2; w0 = we_cnt;
    run_txn(1'b1, 5'h03, 32'hA5A5_0001, lat, rel, dout, oe_pre, oe_any, oe_after);
    model_mem[3] = 32'hA5A5_0001;
    $display("TXN write addr=03 data=a5a50001 lat=%0d rel=%0d", lat, rel);
    checks++;
    if (we_cnt !== w0 + 1) begin errors++; $display("FAIL write_we_count: got %0d expected %0d", we_cnt - w0, 1); end
    checks++;
    if (last_we_addr !== 5'h03 || last_we_data !== 32'hA5A5_0001) begin
      errors++; $display("FAIL write_payload: got %h/%h expected 03/a5a50001", last_we_addr, last_we_data);
    end
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL write_latency: got %0d expected 7", lat); end
    checks++;
    if (rel !== 3) begin errors++; $display("FAIL write_release: got %0d expected 3", rel); end
    checks++;
    if (oe_any !== 1'b0) begin errors++; $display("FAIL write_oe: got %b expected 0", oe_any); end
  endtask

  task automatic test_read();
    int lat, rel, r0;
    logic [31:0] dout;
    bit oe_pre, oe_any, oe_after;
    ack_delay = 0; ovr_en = 1'b1; ovr_val = 32'h1234_5678; r0 = re_cnt;
    run_txn(1'b0, 5'h1F, 32'h0, lat, rel, dout, oe_pre, oe_any, oe_after);
    ovr_en = 1'b0; exp_dout = 32'h1234_5678;
    $display("TXN read addr=1f data=%h lat=%0d rel=%0d", dout, lat, rel);
    checks++;
    if (dout !== 32'h1234_5678) begin errors++; $display("FAIL read_data: got %h expected 12345678", dout); end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL read_latency: got %0d expected 5", lat); end
    checks++;
    if (oe_pre !== 1'b1) begin errors++; $display("FAIL read_oe_setup: got %b expected 1", oe_pre); end
    checks++;
    if (rel !== 3 || oe_after !== 1'b0) begin
      errors++; $display("FAIL read_release: got rel %0d oe %b expected 3 0", rel, oe_after);
    end
    checks++;
    if (re_cnt !== r0 + 1) begin errors++; $display("FAIL read_re_count: got %0d expected 1", re_cnt - r0); end
  endtask

  task automatic test_timeout();
    int lat, rel, t0;
    logic [31:0] dout;
    bit oe_pre, oe_any, oe_after;
    ack_enable = 1'b0; t0 = to_cnt;
    run_txn(1'b0, 5'h09, 32'h0, lat, rel, dout, oe_pre, oe_any, oe_after);
    ack_enable = 1'b1; exp_dout = 32'hFFFF_FFFF;
    $display("TXN timeout-read addr=09 data=%h lat=%0d", dout, lat);
    checks++;
    if (to_cnt !== t0 + 1) begin errors++; $display("FAIL timeout_flag: got %0d pulses expected 1", to_cnt - t0); end
    checks++;
    if (dout !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timeout_data: got %h expected ffffffff", dout); end
    checks++;
    if (lat !== 5 + TIMEOUT) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", lat, 5 + TIMEOUT); end
  endtask

  task automatic test_abort();
    int lat, rel, w0;
    logic [31:0] dout, d;
    bit oe_pre, oe_any, oe_after, saw_low;
    ack_delay = 8; w0 = we_cnt; saw_low = 1'b0; d = $urandom;
    FA = 5'h05; D_IN = d; FWS = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge SYSCLK);
      if (FDTACK !== 1'b1) saw_low = 1'b1;
    end
    FWS = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge SYSCLK);
      if (FDTACK !== 1'b1) saw_low = 1'b1;
    end
    model_mem[5] = d;
    $display("TXN abort-write addr=05 data=%h", d);
    checks++;
    if (we_cnt !== w0 + 1) begin errors++; $display("FAIL abort_we_count: got %0d expected 1", we_cnt - w0); end
    checks++;
    if (saw_low !== 1'b0) begin errors++; $display("FAIL abort_fdtack: got low expected high throughout"); end
    ack_delay = 0;
    run_txn(1'b0, 5'h05, 32'h0, lat, rel, dout, oe_pre, oe_any, oe_after);
    exp_dout = model_mem[5];
    $display("TXN read addr=05 data=%h lat=%0d", dout, lat);
    checks++;
    if (lat !== 5 || dout !== model_mem[5]) begin
      errors++; $display("FAIL abort_recover: got lat %0d data %h expected 5 %h", lat, dout, model_mem[5]);
    end
  endtask

  task automatic test_stray_ack();
    int w0, r0, t0;
    bit bad;
    w0 = we_cnt; r0 = re_cnt; t0 = to_cnt; bad = 1'b0;
    stray_ack = 1'b1;
    @(negedge SYSCLK);
    stray_ack = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge SYSCLK);
      if (FDTACK !== 1'b1 || D_OE !== 1'b0) bad = 1'b1;
    end
    $display("TXN stray-ack in idle");
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL stray_ack_ctrl: got fdtack/oe activity expected none"); end
    checks++;
    if (D_OUT !== exp_dout) begin errors++; $display("FAIL stray_ack_dout: got %h expected %h", D_OUT, exp_dout); end
    checks++;
    if (we_cnt !== w0 || re_cnt !== r0 || to_cnt !== t0) begin
      errors++; $display("FAIL stray_ack_pulses: got we %0d re %0d to %0d expected 0 0 0", we_cnt - w0, re_cnt - r0, to_cnt - t0);
    end
  endtask

  task automatic test_illegal();
    int w0, r0;
    bit saw_low;
    w0 = we_cnt; r0 = re_cnt; saw_low = 1'b0;
    FA = 5'h07; D_IN = $urandom; FWS = 1'b1; FRS = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge SYSCLK);
      if (FDTACK !== 1'b1) saw_low = 1'b1;
    end
    FWS = 1'b0; FRS = 1'b0;
    repeat (5) @(negedge SYSCLK);
    $display("TXN both-strobes addr=07");
    checks++;
    if (we_cnt !== w0 || re_cnt !== r0) begin
      errors++; $display("FAIL illegal_pulses: got we %0d re %0d expected 0 0", we_cnt - w0, re_cnt - r0);
    end
    checks++;
    if (saw_low !== 1'b0) begin errors++; $display("FAIL illegal_fdtack: got low expected high"); end
  endtask

  task automatic test_reset_mid_dtack();
    int lat, rel, r0;
    logic [31:0] dout;
    bit oe_pre, oe_any, oe_after, got, saw_low;
    ack_delay = 0; got = 1'b0; saw_low = 1'b0;
    FA = 5'h02; FRS = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge SYSCLK);
      if (FDTACK === 1'b0) begin got = 1'b1; break; end
    end
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL rst_mid_reach_dtack: got no FDTACK expected low within 20 cycles"); end
    RSTN = 1'b0;
    #1;
    checks++;
    if (FDTACK !== 1'b1 || D_OE !== 1'b0 || D_OUT !== 32'h0) begin
      errors++; $display("FAIL rst_mid_async: got fdtack %b oe %b dout %h expected 1 0 0", FDTACK, D_OE, D_OUT);
    end
    @(negedge SYSCLK);
    RSTN = 1'b1;
    r0 = re_cnt;
    for (int k = 1; k <= 15; k++) begin
      @(negedge SYSCLK);
      if (FDTACK !== 1'b1) saw_low = 1'b1;
    end
    $display("TXN reset-during-dtack addr=02");
    checks++;
    if (re_cnt !== r0 || saw_low !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_restart: got re %0d low %b expected 0 0", re_cnt - r0, saw_low);
    end
    FRS = 1'b0;
    repeat (4) @(negedge SYSCLK);
    run_txn(1'b0, 5'h02, 32'h0, lat, rel, dout, oe_pre, oe_any, oe_after);
    exp_dout = model_mem[2];
    $display("TXN read addr=02 data=%h lat=%0d", dout, lat);
    checks++;
    if (lat !== 5 || dout !== model_mem[2]) begin
      errors++; $display("FAIL rst_mid_toggle: got lat %0d data %h expected 5 %h", lat, dout, model_mem[2]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rel, w0, d;
    logic [31:0] dout, data;
    logic [4:0] a;
    bit wr, oe_pre, oe_any, oe_after;
    for (int n = 0; n < 24; n++) begin
      wr = $urandom_range(0, 1);
      a = 5'($urandom_range(0, 31));
      data = $urandom;
      d = $urandom_range(0, 5);
      ack_delay = d; w0 = we_cnt;
      run_txn(wr, a, data, lat, rel, dout, oe_pre, oe_any, oe_after);
      $display("TXN %0d %s addr=%h data=%h ack_delay=%0d lat=%0d rel=%0d", n, wr ? "write" : "read",
               a, wr ? data : dout, d, lat, rel);
      checks++;
      if (lat !== 5 + d || rel !== 3) begin
        errors++; $display("FAIL rand_timing[%0d]: got lat %0d rel %0d expected %0d 3", n, lat, rel, 5 + d);
      end
      if (wr) begin
        model_mem[a] = data;
        checks++;
        if (we_cnt !== w0 + 1 || last_we_addr !== a || last_we_data !== data || oe_any !== 1'b0) begin
          errors++; $display("FAIL rand_write[%0d]: got we %0d addr %h data %h oe %b expected 1 %h %h 0",
                             n, we_cnt - w0, last_we_addr, last_we_data, oe_any, a, data);
        end
      end else begin
        exp_dout = model_mem[a];
        checks++;
        if (dout !== model_mem[a] || oe_pre !== 1'b1 || oe_after !== 1'b0) begin
          errors++; $display("FAIL rand_read[%0d]: got data %h oe_pre %b oe_after %b expected %h 1 0",
                             n, dout, oe_pre, oe_after, model_mem[a]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = init_word(5'(i));
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_abort();
    test_stray_ack();
    test_illegal();
    test_reset_mid_dtack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
